guitar_input_ctrl: RTL and testbench

GUITAR_INPUT_CTRL -- requirements
Module: guitar_input_ctrl

---
 rtl/guitar_input_pkg.sv | 36 +++
 rtl/debounce_cell.sv | 58 +++++
 rtl/guitar_input_ctrl.sv | 67 ++++++
 tb/tb_guitar_input_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_input_pkg.sv
// Shared constants for the guitar controller input block: input indices,
// status-word field layout and debounce counter sizing.
package guitar_input_pkg;

    localparam int NUM_INPUTS = 9;

    localparam int FRET0   = 0;
    localparam int FRET1   = 1;
    localparam int FRET2   = 2;
    localparam int FRET3   = 3;
    localparam int FRET4   = 4;
    localparam int STRUM   = 5;
    localparam int START   = 6;
    localparam int P2_UP   = 7;
    localparam int P2_DOWN = 8;

    localparam int STATUS_W      = 32;
    localparam int LEVEL_LSB     = 0;
    localparam int LEVEL_W       = NUM_INPUTS;
    localparam int EVENT_LSB     = LEVEL_LSB + LEVEL_W;
    localparam int EVENT_W       = NUM_INPUTS;
    localparam int STRUM_CNT_LSB = EVENT_LSB + EVENT_W;
    localparam int STRUM_CNT_W   = 6;

    localparam int DEBOUNCE_MIN = 2;
    localparam int DEBOUNCE_MAX = 65535;

    typedef logic [NUM_INPUTS-1:0]  input_vec_t;
    typedef logic [STRUM_CNT_W-1:0] strum_cnt_t;

    // Counter only needs to reach cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-flop synchronizer followed by an optional stable-sample
// debouncer, built only when GUITAR_INPUT_DEBOUNCE_EN is defined.
module debounce_cell
    import guitar_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic raw,
    output logic level
);

    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_cycles
        $error("debounce_cell: DEBOUNCE_CYCLES out of range");
    end

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

`ifdef GUITAR_INPUT_DEBOUNCE_EN
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    // --- stage p2: level flips only after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync_p1 == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync_p1;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = stable_q;
`else
    assign level = sync_p1;
`endif

endmodule

// File: rtl/guitar_input_ctrl.sv
// Guitar controller input block: 9 debounced inputs, sticky press events and a
// strum counter packed into the r29 status word. Debounce: GUITAR_INPUT_DEBOUNCE_EN.
module guitar_input_ctrl
    import guitar_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic [4:0]            fret_raw,
    input  logic                  strum_raw,
    input  logic                  start_raw,
    input  logic                  p2_up_raw,
    input  logic                  p2_down_raw,
    input  logic                  event_clr,
    input  logic [NUM_INPUTS-1:0] event_clr_mask,
    output logic [STATUS_W-1:0]   external_inputs
);

    input_vec_t raw_vec;
    input_vec_t stable;
    input_vec_t lvl_q;
    input_vec_t event_q;
    input_vec_t rise;
    input_vec_t clr_vec;
    strum_cnt_t strum_cnt_q;

    assign raw_vec = {p2_down_raw, p2_up_raw, start_raw, strum_raw, fret_raw};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clock     (clock),
            .ctrl_reset(ctrl_reset),
            .raw       (raw_vec[i]),
            .level     (stable[i])
        );
    end

    // lvl_q doubles as the previous stable level, so rise is the 0->1 edge.
    assign rise    = stable & ~lvl_q;
    assign clr_vec = event_clr ? event_clr_mask : '0;

    // --- stage p3: status registers
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            lvl_q       <= '0;
            event_q     <= '0;
            strum_cnt_q <= '0;
        end else begin
            lvl_q   <= stable;
            event_q <= (event_q & ~clr_vec) | rise;
            if (rise[STRUM]) begin
                strum_cnt_q <= strum_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        external_inputs = '0;
        external_inputs[LEVEL_LSB +: LEVEL_W]         = lvl_q;
        external_inputs[EVENT_LSB +: EVENT_W]         = event_q;
        external_inputs[STRUM_CNT_LSB +: STRUM_CNT_W] = strum_cnt_q;
    end

endmodule

// File: tb/tb_guitar_input_ctrl.sv
// Self-checking bench for guitar_input_ctrl with DEBOUNCE_CYCLES=4; covers
// both GUITAR_INPUT_DEBOUNCE_EN builds.
module tb_guitar_input_ctrl;

    localparam int DEB_N = 4;
`ifdef GUITAR_INPUT_DEBOUNCE_EN
    localparam int LAT = 2 + DEB_N + 1;
`else
    localparam int LAT = 3;
`endif

    logic        clock;
    logic        ctrl_reset;
    logic [4:0]  fret_raw;
    logic        strum_raw;
    logic        start_raw;
    logic        p2_up_raw;
    logic        p2_down_raw;
    logic        event_clr;
    logic [8:0]  event_clr_mask;
    logic [31:0] external_inputs;

    int total;
    int bad;

    guitar_input_ctrl #(.DEBOUNCE_CYCLES(DEB_N)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .fret_raw       (fret_raw),
        .strum_raw      (strum_raw),
        .start_raw      (start_raw),
        .p2_up_raw      (p2_up_raw),
        .p2_down_raw    (p2_down_raw),
        .event_clr      (event_clr),
        .event_clr_mask (event_clr_mask),
        .external_inputs(external_inputs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: raw seen through two sample delays, a level that
    // changes after DEB_N consecutive disagreeing samples, and status fields.
    bit [8:0]  m_s0, m_s1, m_st, m_lvl, m_ev, m_cur, m_rise;
    int        m_run [9];
    bit [5:0]  m_cnt;
    logic [31:0] m_exp;

    always @(posedge clock) begin
        if (!ctrl_reset) begin
            m_s0 = '0; m_s1 = '0; m_st = '0; m_lvl = '0; m_ev = '0; m_cnt = '0;
            for (int i = 0; i < 9; i++) m_run[i] = 0;
        end else begin
`ifdef GUITAR_INPUT_DEBOUNCE_EN
            m_cur = m_st;
`else
            m_cur = m_s1;
`endif
            m_rise = m_cur & ~m_lvl;
            m_lvl  = m_cur;
            if (event_clr) m_ev = m_ev & ~event_clr_mask;
            m_ev = m_ev | m_rise;
            if (m_rise[5]) m_cnt = m_cnt + 6'd1;
            for (int i = 0; i < 9; i++) begin
                if (m_s1[i] != m_st[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB_N) begin
                        m_st[i]  = m_s1[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s1 = m_s0;
            m_s0 = {p2_down_raw, p2_up_raw, start_raw, strum_raw, fret_raw};
        end
        m_exp = {8'h00, m_cnt, m_ev, m_lvl};
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic set_raw(input logic [8:0] v);
        {p2_down_raw, p2_up_raw, start_raw, strum_raw, fret_raw} = v;
    endtask

    task automatic do_reset();
        ctrl_reset = 1'b0;
        set_raw(9'h000);
        event_clr = 1'b0;
        event_clr_mask = '0;
        step(3);
        ctrl_reset = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_raw(9'($urandom));
            event_clr = 1'($urandom);
            event_clr_mask = 9'($urandom);
            step(1);
            total++;
            if (external_inputs !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold: got %h expected %h", external_inputs, 32'h0);
            end
        end
        // START held through release must still yield exactly one press event.
        set_raw(9'h040);
        event_clr = 1'b0;
        ctrl_reset = 1'b1;
        step(LAT + 2);
        total++;
        if (external_inputs !== 32'h0000_8040) begin
            bad++;
            $display("FAIL reset_held_input: got %h expected %h", external_inputs, 32'h0000_8040);
        end
    endtask

    task automatic test_fret0();
        logic [31:0] exp;
        do_reset();
        fret_raw[0] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            exp = (k >= LAT) ? 32'h0000_0201 : 32'h0;
            total++;
            if (external_inputs !== exp) begin
                bad++;
                $display("FAIL fret0_latency k=%0d: got %h expected %h", k, external_inputs, exp);
            end
        end
    endtask

    task automatic test_p2_down();
        logic [31:0] exp;
        do_reset();
        p2_down_raw = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            exp = (k >= LAT) ? 32'h0002_0100 : 32'h0;
            total++;
            if (external_inputs !== exp) begin
                bad++;
                $display("FAIL p2_down_latency k=%0d: got %h expected %h", k, external_inputs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] exp;
        do_reset();
        strum_raw = 1'b1;
        step(2);
        strum_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            total++;
            if (external_inputs !== m_exp) begin
                bad++;
                $display("FAIL glitch_model k=%0d: got %h expected %h", k, external_inputs, m_exp);
            end
        end
`ifdef GUITAR_INPUT_DEBOUNCE_EN
        exp = 32'h0;
`else
        exp = 32'h0004_4000;
`endif
        total++;
        if ((external_inputs & 32'h00FC_4020) !== exp) begin
            bad++;
            $display("FAIL glitch_strum: got %h expected %h", external_inputs & 32'h00FC_4020, exp);
        end
    endtask

    task automatic test_strum_count();
        logic [5:0] exp;
        do_reset();
        for (int p = 1; p <= 64; p++) begin
            strum_raw = 1'b1;
            step(LAT + 1);
            strum_raw = 1'b0;
            step(LAT + 1);
            exp = 6'(p % 64);
            total++;
            if (external_inputs[23:18] !== exp || external_inputs[14] !== 1'b1) begin
                bad++;
                $display("FAIL strum_count p=%0d: got cnt=%0d ev=%b expected cnt=%0d ev=1",
                         p, external_inputs[23:18], external_inputs[14], exp);
            end
        end
    endtask

    task automatic test_event_clr();
        do_reset();
        set_raw(9'h1FF);
        step(LAT + 1);
        set_raw(9'h000);
        step(LAT + 1);
        total++;
        if (external_inputs[17:9] !== 9'h1FF) begin
            bad++;
            $display("FAIL event_all_set: got %h expected %h", external_inputs[17:9], 9'h1FF);
        end
        event_clr = 1'b1; event_clr_mask = 9'h005;
        step(1);
        event_clr = 1'b0; event_clr_mask = 9'h000;
        total++;
        if (external_inputs[17:9] !== 9'h1FA) begin
            bad++;
            $display("FAIL event_clr_mask: got %h expected %h", external_inputs[17:9], 9'h1FA);
        end
        event_clr = 1'b1; event_clr_mask = 9'h040;
        step(1);
        event_clr = 1'b0; event_clr_mask = 9'h000;
        total++;
        if (external_inputs[15] !== 1'b0) begin
            bad++;
            $display("FAIL event_clr_start: got %b expected 0", external_inputs[15]);
        end
        start_raw = 1'b1;
        step(LAT - 1);
        event_clr = 1'b1; event_clr_mask = 9'h040;
        step(1);
        event_clr = 1'b0; event_clr_mask = 9'h000;
        total++;
        if (external_inputs[15] !== 1'b1 || external_inputs[6] !== 1'b1) begin
            bad++;
            $display("FAIL event_set_wins: got ev=%b lvl=%b expected 1 1",
                     external_inputs[15], external_inputs[6]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        do_reset();
        fret_raw[2] = 1'b1;
        step(2);
        ctrl_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            total++;
            if (external_inputs !== 32'h0) begin
                bad++;
                $display("FAIL reset_mid_hold: got %h expected %h", external_inputs, 32'h0);
            end
        end
        ctrl_reset = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            exp = (k >= LAT) ? 32'h0000_0804 : 32'h0;
            total++;
            if (external_inputs !== exp) begin
                bad++;
                $display("FAIL reset_mid_release k=%0d: got %h expected %h", k, external_inputs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] rv;
        do_reset();
        rv = '0;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 9; b++) begin
                if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
            end
            set_raw(rv);
            event_clr = ($urandom_range(0, 7) == 0);
            event_clr_mask = 9'($urandom);
            step(1);
            total++;
            if (external_inputs !== m_exp) begin
                bad++;
                $display("FAIL random k=%0d: got %h expected %h", k, external_inputs, m_exp);
            end
        end
        event_clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        ctrl_reset = 1'b0;
        set_raw(9'h000);
        event_clr = 1'b0;
        event_clr_mask = '0;
        step(2);
        test_reset();
        test_fret0();
        test_p2_down();
        test_glitch();
        test_strum_count();
        test_event_clr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
